// File: rtl/mux_ctrl_pkg.sv
// Shared types and helpers for the 4:1 round-robin mux controller.
package mux_ctrl_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Rotate the priority pointer one step; the 2-bit add wraps 3 -> 0.
    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] sel);
        return sel + 2'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, modulo 4.
import mux_ctrl_pkg::*;

module rr_pick (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any_req,
    output logic [SEL_W-1:0]   pick
);

    logic [SEL_W-1:0] idx;
    logic             found;

    assign any_req = |req;

    always_comb begin
        pick  = ptr;
        found = 1'b0;
        idx   = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr + SEL_W'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_4_1_rr_ctrl.sv
// Round-robin arbiter/sequencer sharing one valid/ready output channel between
// four requesters, with each grant bounded to MAX_BURST transfers.
//
//  state | meaning
//  IDLE  | no grant; outputs quiet; arbitrate on req_in at the next edge
//  BUSY  | requester sel_out owns the channel until drop or burst limit
import mux_ctrl_pkg::*;

module mux_4_1_rr_ctrl #(
    parameter int W         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [NUM_REQ-1:0]   req_in,
    input  logic [NUM_REQ*W-1:0] data_in,
    output logic [NUM_REQ-1:0]   ack_out,
    output logic [W-1:0]         y_out,
    output logic                 y_valid_out,
    input  logic                 y_ready_in,
    output logic [SEL_W-1:0]     sel_out,
    output logic                 busy_out
);

    localparam logic [7:0] LAST_CNT = 8'(MAX_BURST - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [7:0]       burst_cnt_q, burst_cnt_d;

    logic             any_req;
    logic [SEL_W-1:0] pick;
    logic             xfer;

    rr_pick u_pick (
        .req     (req_in),
        .ptr     (ptr_q),
        .any_req (any_req),
        .pick    (pick)
    );

    assign xfer = (state_q == BUSY) && req_in[sel_q] && y_ready_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            ptr_q       <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    sel_d       = pick;
                    burst_cnt_d = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (xfer)
                    burst_cnt_d = burst_cnt_q + 8'd1;
                // A dropped request ends the grant without counting as a transfer.
                if (!req_in[sel_q] || (xfer && burst_cnt_q == LAST_CNT)) begin
                    state_d = IDLE;
                    ptr_d   = next_ptr(sel_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        y_out       = '0;
        y_valid_out = 1'b0;
        ack_out     = '0;
        if (state_q == BUSY) begin
            y_out          = data_in[sel_q*W +: W];
            y_valid_out    = req_in[sel_q];
            ack_out[sel_q] = xfer;
        end
    end

    assign sel_out  = sel_q;
    assign busy_out = (state_q == BUSY);

endmodule

// File: tb/tb_mux_4_1_rr_ctrl.sv
// Directed self-checking bench for mux_4_1_rr_ctrl (W=8, MAX_BURST=4).
module tb_mux_4_1_rr_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [3:0]  req_in;
    logic [31:0] data_in;
    logic [3:0]  ack_out;
    logic [7:0]  y_out;
    logic        y_valid_out;
    logic        y_ready_in;
    logic [1:0]  sel_out;
    logic        busy_out;

    int n_assert = 0;
    int n_fail   = 0;

    mux_4_1_rr_ctrl #(.W(8), .MAX_BURST(4)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .req_in      (req_in),
        .data_in     (data_in),
        .ack_out     (ack_out),
        .y_out       (y_out),
        .y_valid_out (y_valid_out),
        .y_ready_in  (y_ready_in),
        .sel_out     (sel_out),
        .busy_out    (busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are settled before this is called, so combinational outputs are current.
    task automatic check_all(input string tag, input logic busy, input logic valid,
                             input logic [3:0] ack, input logic [7:0] y, input logic [1:0] sel);
        #1;
        chk({tag, ".busy"},  32'(busy_out),    32'(busy));
        chk({tag, ".valid"}, 32'(y_valid_out), 32'(valid));
        chk({tag, ".ack"},   32'(ack_out),     32'(ack));
        chk({tag, ".y"},     32'(y_out),       32'(y));
        chk({tag, ".sel"},   32'(sel_out),     32'(sel));
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
    endtask

    initial begin
        logic [7:0] dat [4];
        int         order [5];
        dat   = '{8'h11, 8'h22, 8'h33, 8'h44};
        order = '{0, 1, 2, 3, 0};

        // Reset held two cycles with all requests up
        rst_in     = 1'b1;
        req_in     = 4'hF;
        y_ready_in = 1'b1;
        data_in    = {dat[3], dat[2], dat[1], dat[0]};
        tick();
        check_all("rst_c1", 0, 0, 4'h0, 8'h00, 2'd0);
        tick();
        check_all("rst_c2", 0, 0, 4'h0, 8'h00, 2'd0);
        rst_in = 1'b0;
        tick();
        check_all("rst_first_grant", 1, 1, 4'b0001, dat[0], 2'd0);

        // Full contention: 0,1,2,3,0 with 4 acks then one bubble each
        for (int g = 0; g < 5; g++) begin
            for (int b = 0; b < 4; b++) begin
                if (!(g == 0 && b == 0)) check_all($sformatf("rr_g%0d_b%0d", g, b), 1, 1,
                                                  4'(1 << order[g]), dat[order[g]], 2'(order[g]));
                tick();
            end
            check_all($sformatf("rr_bubble%0d", g), 0, 0, 4'h0, 8'h00, 2'(order[g]));
            tick();
        end
        check_all("rr_wrap_to1", 1, 1, 4'b0010, dat[1], 2'd1);

        // Single requester 2: 4 acks, bubble, regrant to 2 via wrapped search
        do_reset();
        req_in  = 4'b0100;
        data_in = 32'h00A5_0000;
        check_all("single_idle", 0, 0, 4'h0, 8'h00, 2'd0);
        tick();
        for (int b = 0; b < 4; b++) begin
            check_all($sformatf("single_b%0d", b), 1, 1, 4'b0100, 8'hA5, 2'd2);
            tick();
        end
        check_all("single_bubble", 0, 0, 4'h0, 8'h00, 2'd2);
        tick();
        check_all("single_regrant", 1, 1, 4'b0100, 8'hA5, 2'd2);

        // Backpressure during requester 1's burst
        do_reset();
        req_in  = 4'b0010;
        data_in = 32'h0000_5C00;
        tick();
        check_all("bp_x1", 1, 1, 4'b0010, 8'h5C, 2'd1);
        tick();
        check_all("bp_x2", 1, 1, 4'b0010, 8'h5C, 2'd1);
        tick();
        y_ready_in = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check_all($sformatf("bp_stall%0d", s), 1, 1, 4'h0, 8'h5C, 2'd1);
            tick();
        end
        y_ready_in = 1'b1;
        check_all("bp_x3", 1, 1, 4'b0010, 8'h5C, 2'd1);
        tick();
        check_all("bp_x4", 1, 1, 4'b0010, 8'h5C, 2'd1);
        tick();
        check_all("bp_end", 0, 0, 4'h0, 8'h00, 2'd1);

        // Early drop of requester 1 with requester 3 waiting
        do_reset();
        req_in  = 4'b1010;
        data_in = 32'h8800_7700;
        tick();
        check_all("drop_x1", 1, 1, 4'b0010, 8'h77, 2'd1);
        tick();
        check_all("drop_x2", 1, 1, 4'b0010, 8'h77, 2'd1);
        tick();
        req_in = 4'b1000;
        check_all("drop_cycle", 1, 0, 4'h0, 8'h77, 2'd1);
        tick();
        // Re-raise 1: a pointer of 2 must still favour 3
        req_in = 4'b1010;
        check_all("drop_bubble", 0, 0, 4'h0, 8'h00, 2'd1);
        tick();
        check_all("drop_next3", 1, 1, 4'b1000, 8'h88, 2'd3);

        // Reset mid-burst of requester 2 (pointer was 2 before reset)
        do_reset();
        req_in  = 4'b0010;
        data_in = 32'h0033_2200;
        tick();
        check_all("mrst_g1", 1, 1, 4'b0010, 8'h22, 2'd1);
        req_in = 4'b0100;
        tick();
        check_all("mrst_idle", 0, 0, 4'h0, 8'h00, 2'd1);
        tick();
        check_all("mrst_x1", 1, 1, 4'b0100, 8'h33, 2'd2);
        tick();
        rst_in = 1'b1;
        check_all("mrst_x2", 1, 1, 4'b0100, 8'h33, 2'd2);
        tick();
        rst_in = 1'b0;
        req_in = 4'b0110;
        check_all("mrst_after", 0, 0, 4'h0, 8'h00, 2'd0);
        tick();
        check_all("mrst_ptr0", 1, 1, 4'b0010, 8'h22, 2'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
